opl3_sched: RTL and testbench
=============================

// Module: opl3_sched
// PURPOSE
//  Top-level scheduler for the OPL3 sequencer and its shared ~1.7KB OPL3 struct DP-RAM port.
//  Generates the sample-rate tick and pulses the sequencer's rd. Captures the A/B sample pair.
//  Queues host register-struct writes and drains them into RAM only while the sequencer is idle.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency (>= 45 MHz for 36 operators)
//  SAMPLE_HZ  44_100      output sample rate
//  FIFO_DEPTH 4           host write queue depth (power of 2)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high
//  host_wr       in   1   host RAM write strobe (1 clk pulse)
//  host_addr     in   12  host RAM word address
//  host_wdata    in   16  host RAM write data
//  host_full     out  1   queue full; host_wr ignored while high
//  host_drop     out  1   sticky: a host_wr was dropped because the queue was full
//  seq_rd        out  1   start pulse to the sequencer
//  seq_ready     in   1   sequencer idle
//  seq_a/seq_b   in   16  sequencer left/right sample
//  seq_ram_wr    in   1   sequencer RAM write enable
//  seq_ram_addr  in   12  sequencer RAM address
//  seq_ram_wdata in   16  sequencer RAM write data
//  ram_wr        out  1   muxed RAM write enable
//  ram_addr      out  12  muxed RAM address
//  ram_wdata     out  16  muxed RAM write data
//  out_l/out_r   out  16  latched sample pair
//  out_valid     out  1   1-clk pulse when out_l/out_r update
//  overrun       out  1   sticky: a tick arrived while the previous one was still pending
//  overrun_clr   in   1   clears overrun and host_drop
// BEHAVIOUR
//  Reset:
//   - Outputs: all 0 (out_l, out_r, out_valid, seq_rd, ram_wr, overrun, host_drop, host_full).
//   - Internal: accumulator 0, queue empty, pend_tick 0, state IDLE.
//   - Sequencer shares the same reset, so reset mid-run is clean.
//  Tick generator, 32-bit:
//   - If acc + SAMPLE_HZ >= CLK_HZ: acc <= acc + SAMPLE_HZ - CLK_HZ, tick=1.
//   - Else: acc <= acc + SAMPLE_HZ.
//   - Tick sets pend_tick.
//   - If pend_tick is already 1: set overrun; the tick is merged, not queued.
//  States:
//   - IDLE: pop one queue entry per clk onto ram_* (ram_wr=1).
//     Exit to START when pend_tick && queue empty && seq_ready, evaluated after this cycle's pop.
//   - START: seq_rd=1 for exactly 1 clk; clear pend_tick; RAM mux -> sequencer; go to WAIT.
//   - WAIT: 1 clk guard (seq_ready may still read 1); RAM mux -> sequencer; go to RUN.
//   - RUN: RAM mux -> sequencer (ram_* = seq_ram_* combinationally). No pops.
//     Exit to CAPTURE on seq_ready=1.
//   - CAPTURE: out_l<=seq_a, out_r<=seq_b, out_valid=1 (1 clk), RAM mux -> host; go to IDLE.
//  Queue:
//   - Push on host_wr && !host_full.
//   - Simultaneous push and pop is allowed while full: pop frees the slot the same clk, host_full = count==DEPTH.
//   - Pop is first-word-fall-through; ram_* driven from the head; registered ram_wr when host-selected.
//  Latency:
//   - Host write into an idle, empty queue reaches ram_wr 1 clk after host_wr.
//   - Tick to seq_rd: 1 clk with an empty queue, otherwise +1 clk per queued word.
//  Host writes never reach RAM in START/WAIT/RUN.
//   - Worst-case deferral is one sequencer run.
//   - Worst-case tick delay is FIFO_DEPTH clks.
//  overrun_clr concurrent with a new overrun event: set wins.
// STRUCTURE
//  - Package opl3_sched_pkg: state enum (IDLE, START, WAIT, RUN, CAPTURE), RAM_AW=12, RAM_DW=16.
//  - Sub-module opl3_host_fifo: {addr, data} FWFT queue of FIFO_DEPTH with full/empty/count.
//  - Top holds the tick accumulator, FSM and RAM mux.
// TESTING
//  Bench uses a sequencer model: ready drops 1 clk after rd and returns after N clks; A=0x1234, B=0xFEDC.
//  1. CLK_HZ=100, SAMPLE_HZ=1, N=40 -> seq_rd every 100 clks; out_valid 41-43 clks after each seq_rd; out_l=0x1234, out_r=0xFEDC.
//  2. host_wr addr 0x123 data 0xBEEF during RUN -> no ram_wr until CAPTURE; ram_wr with 0x123/0xBEEF in the first IDLE clk.
//  3. 3 queued writes when a tick lands in IDLE -> 3 consecutive ram_wr clks, then seq_rd on the next clk.
//  4. N=150, period 100 -> overrun=1, one tick merged; overrun_clr -> overrun=0.
//  5. 5 back-to-back host_wr during RUN with DEPTH=4 -> host_full after the 4th; 5th dropped; host_drop=1; exactly 4 ram_wr after RUN.
//  6. reset asserted mid-RUN -> next clk all outputs 0, state IDLE; ram_* host-selected with ram_wr=0; next tick starts normally.

Source files
------------

// File: rtl/opl3_sched_pkg.sv
`default_nettype none
// ============================================================================
// opl3_sched_pkg : shared types for the OPL3 scheduler slice
// Rev 1.0
// ============================================================================
package opl3_sched_pkg;

  localparam int RAM_AW = 12;
  localparam int RAM_DW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [RAM_DW-1:0] data;
  } host_wr_t;

endpackage
`default_nettype wire

// File: rtl/opl3_sched_if.sv
`default_nettype none
// ============================================================================
// opl3_sched_if : host queue, sequencer, shared-RAM and sample signals
// Rev 1.0
// ============================================================================
interface opl3_sched_if;
  import opl3_sched_pkg::*;

  logic              host_wr;
  logic [RAM_AW-1:0] host_addr;
  logic [RAM_DW-1:0] host_wdata;
  logic              host_full;
  logic              host_drop;
  logic              seq_rd;
  logic              seq_ready;
  logic [RAM_DW-1:0] seq_a;
  logic [RAM_DW-1:0] seq_b;
  logic              seq_ram_wr;
  logic [RAM_AW-1:0] seq_ram_addr;
  logic [RAM_DW-1:0] seq_ram_wdata;
  logic              ram_wr;
  logic [RAM_AW-1:0] ram_addr;
  logic [RAM_DW-1:0] ram_wdata;
  logic [RAM_DW-1:0] out_l;
  logic [RAM_DW-1:0] out_r;
  logic              out_valid;
  logic              overrun;
  logic              overrun_clr;

  modport slave (
    input  host_wr, host_addr, host_wdata, seq_ready, seq_a, seq_b,
           seq_ram_wr, seq_ram_addr, seq_ram_wdata, overrun_clr,
    output host_full, host_drop, seq_rd, ram_wr, ram_addr, ram_wdata,
           out_l, out_r, out_valid, overrun
  );

  modport master (
    output host_wr, host_addr, host_wdata, seq_ready, seq_a, seq_b,
           seq_ram_wr, seq_ram_addr, seq_ram_wdata, overrun_clr,
    input  host_full, host_drop, seq_rd, ram_wr, ram_addr, ram_wdata,
           out_l, out_r, out_valid, overrun
  );

endinterface
`default_nettype wire

// File: rtl/opl3_host_fifo.sv
`default_nettype none
// ============================================================================
// opl3_host_fifo : first-word-fall-through queue of host RAM writes
// Rev 1.0
// ============================================================================
module opl3_host_fifo
  import opl3_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  host_wr_t               wdata,
  output host_wr_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                   c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]     c_FULL  = (c_PTR_W + 1)'(DEPTH);

  host_wr_t           r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  // Storage is cleared so the idle RAM bus shows zeros after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '{default: '0};
    end else if (push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/opl3_sched.sv
`default_nettype none
// ============================================================================
// opl3_sched : sample-tick generator, sequencer handshake and shared RAM mux
// Rev 1.0
// ============================================================================
module opl3_sched
  import opl3_sched_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SAMPLE_HZ  = 44_100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  opl3_sched_if.slave  bus
);

  localparam int          c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] c_CLK_HZ    = 32'(CLK_HZ);
  localparam logic [31:0] c_SAMPLE_HZ = 32'(SAMPLE_HZ);

  state_t            r_state;
  logic [31:0]       r_acc;
  logic              r_pend_tick;
  logic              r_overrun;
  logic              r_host_drop;
  logic              r_seq_rd;
  logic              r_out_valid;
  logic [RAM_DW-1:0] r_out_l;
  logic [RAM_DW-1:0] r_out_r;

  logic [31:0]        w_acc_sum;
  logic               w_tick;
  logic               w_push;
  logic               w_pop;
  logic               w_drained;
  logic               w_go;
  logic               w_host_sel;
  logic               w_full;
  logic               w_empty;
  logic [c_CNT_W-1:0] w_count;
  host_wr_t           w_wdata;
  host_wr_t           w_head;

  assign w_acc_sum = r_acc + c_SAMPLE_HZ;
  assign w_tick    = (w_acc_sum >= c_CLK_HZ);

  assign w_wdata   = '{addr: bus.host_addr, data: bus.host_wdata};
  assign w_pop     = (r_state == IDLE) && !w_empty;
  // A pop in the same clock frees the slot, so a write arriving while full is kept.
  assign w_push    = bus.host_wr && (!w_full || w_pop);
  // Start is decided on the queue as it will be after this clock's pop.
  assign w_drained = (w_count == {{(c_CNT_W-1){1'b0}}, w_pop});
  assign w_go      = (r_pend_tick || w_tick) && w_drained && bus.seq_ready;

  opl3_host_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_host_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_pend_tick <= 1'b0;
      r_overrun   <= 1'b0;
      r_host_drop <= 1'b0;
    end else begin
      r_acc       <= w_tick ? (w_acc_sum - c_CLK_HZ) : w_acc_sum;
      // The tick that launches a run is consumed on the way into START.
      r_pend_tick <= (r_state == IDLE && w_go) ? 1'b0 : (r_pend_tick || w_tick);
      r_overrun   <= (w_tick && r_pend_tick) || (r_overrun && !bus.overrun_clr);
      r_host_drop <= (bus.host_wr && !w_push) || (r_host_drop && !bus.overrun_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_seq_rd    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_l     <= '0;
      r_out_r     <= '0;
    end else begin
      r_seq_rd    <= 1'b0;
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state  <= START;
            r_seq_rd <= 1'b1;
          end
        end
        START:   r_state <= WAIT;
        // seq_ready may not have dropped yet, so it is ignored here.
        WAIT:    r_state <= RUN;
        RUN: begin
          if (bus.seq_ready) begin
            r_state     <= CAPTURE;
            r_out_l     <= bus.seq_a;
            r_out_r     <= bus.seq_b;
            r_out_valid <= 1'b1;
          end
        end
        CAPTURE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_host_sel    = (r_state == IDLE) || (r_state == CAPTURE);

  assign bus.ram_wr    = w_host_sel ? w_pop       : bus.seq_ram_wr;
  assign bus.ram_addr  = w_host_sel ? w_head.addr : bus.seq_ram_addr;
  assign bus.ram_wdata = w_host_sel ? w_head.data : bus.seq_ram_wdata;

  assign bus.host_full = w_full;
  assign bus.host_drop = r_host_drop;
  assign bus.seq_rd    = r_seq_rd;
  assign bus.out_l     = r_out_l;
  assign bus.out_r     = r_out_r;
  assign bus.out_valid = r_out_valid;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_opl3_sched.sv
`default_nettype none
// ============================================================================
// tb_opl3_sched : directed bench with a sequencer model and write/sample scoreboards
// Rev 1.0
// ============================================================================
module tb_opl3_sched;
  import opl3_sched_pkg::*;

  localparam int          CLK_HZ    = 100;
  localparam int          SAMPLE_HZ = 1;
  localparam int          DEPTH     = 4;
  localparam logic [11:0] SEQ_ADDR  = 12'hABC;
  localparam logic [15:0] SEQ_DATA  = 16'hC0DE;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_run = 40;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opl3_sched_if bus ();

  opl3_sched #(
    .CLK_HZ     (CLK_HZ),
    .SAMPLE_HZ  (SAMPLE_HZ),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sequencer model: busy from 1 clk after seq_rd for n_run clks, writing RAM while busy.
  logic sq_ready;
  int   sq_cnt;
  always @(posedge clk) begin
    if (reset) begin
      sq_ready <= 1'b1;
      sq_cnt   <= 0;
    end else if (bus.seq_rd) begin
      sq_ready <= 1'b0;
      sq_cnt   <= n_run;
    end else if (!sq_ready) begin
      if (sq_cnt <= 1) sq_ready <= 1'b1;
      sq_cnt <= sq_cnt - 1;
    end
  end

  assign bus.seq_ready     = sq_ready;
  assign bus.seq_a         = 16'h1234;
  assign bus.seq_b         = 16'hFEDC;
  assign bus.seq_ram_wr    = !sq_ready;
  assign bus.seq_ram_addr  = SEQ_ADDR;
  assign bus.seq_ram_wdata = SEQ_DATA;

  logic [27:0] exp_wr_q [$];
  int          samp_n_q [$];
  int          samp_c_q [$];
  int          rd_q [$];
  int          ov_q [$];
  int          hw_q [$];
  logic [27:0] m_exp;
  int          m_n;
  int          m_c;
  int          m_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      samp_n_q.delete();
      samp_c_q.delete();
    end else begin
      if (bus.seq_rd) begin
        rd_q.push_back(cyc);
        samp_n_q.push_back(n_run);
        samp_c_q.push_back(cyc);
      end
      if (bus.out_valid) begin
        ov_q.push_back(cyc);
        if (samp_c_q.size() == 0) begin
          chk("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          m_n   = samp_n_q.pop_front();
          m_c   = samp_c_q.pop_front();
          m_lat = cyc - m_c;
          chk("out_l", 32'(bus.out_l), 32'h1234);
          chk("out_r", 32'(bus.out_r), 32'hFEDC);
          chk("rd_to_valid_in_window", 32'(m_lat >= m_n + 1 && m_lat <= m_n + 3), 32'd1);
        end
      end
      if (!sq_ready) begin
        chk("ram_mux_seq", {3'b0, bus.ram_wr, bus.ram_addr, bus.ram_wdata},
            {3'b0, 1'b1, SEQ_ADDR, SEQ_DATA});
      end else if (bus.ram_wr) begin
        hw_q.push_back(cyc);
        if (exp_wr_q.size() == 0) begin
          chk("ram_wr_unexpected", 32'(bus.ram_wr), 32'd0);
        end else begin
          m_exp = exp_wr_q.pop_front();
          chk("ram_wr_addr_data", {4'b0, bus.ram_addr, bus.ram_wdata}, {4'b0, m_exp});
        end
      end
    end
  end

  function automatic int qlen(input int which);
    case (which)
      0:       return rd_q.size();
      1:       return ov_q.size();
      default: return hw_q.size();
    endcase
  endfunction

  // which: 0 = seq_rd events, 1 = out_valid events, 2 = host RAM writes
  task automatic wait_len(input string tag, input int which, input int target, input int budget);
    for (int i = 0; i < budget && qlen(which) < target; i++) begin
      @(posedge clk); #1;
    end
    if (qlen(which) < target) chk(tag, 32'(qlen(which)), 32'(target));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic host_write(input logic [11:0] a, input logic [15:0] d, input bit accepted);
    bus.host_wr    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    if (accepted) exp_wr_q.push_back({a, d});
    @(posedge clk); #1;
    bus.host_wr = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_l"},     32'(bus.out_l),     32'd0);
    chk({tag, "_out_r"},     32'(bus.out_r),     32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_seq_rd"},    32'(bus.seq_rd),    32'd0);
    chk({tag, "_ram_wr"},    32'(bus.ram_wr),    32'd0);
    chk({tag, "_overrun"},   32'(bus.overrun),   32'd0);
    chk({tag, "_host_drop"}, 32'(bus.host_drop), 32'd0);
    chk({tag, "_host_full"}, 32'(bus.host_full), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int kr;
    int t;
    int nh;
    int nr;
    bus.host_wr     = 1'b0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
    bus.overrun_clr = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    k0    = cyc;
    reset = 1'b0;

    // Host write into an idle, empty queue reaches RAM one clock later.
    idle(1);
    t = cyc;
    host_write(12'h0A5, 16'h5A5A, 1'b1);
    idle(1);
    chk("idle_wr_count", 32'(hw_q.size()), 32'd1);
    if (hw_q.size() > 0) chk("idle_wr_latency", 32'(hw_q[$]), 32'(t + 1));

    // 1. Tick period and sample capture.
    wait_len("timeout_rd_x3", 0, 3, 400);
    if (rd_q.size() >= 3) begin
      chk("first_rd_cycle", 32'(rd_q[0]), 32'(k0 + 100));
      chk("rd_period_a",    32'(rd_q[1] - rd_q[0]), 32'd100);
      chk("rd_period_b",    32'(rd_q[2] - rd_q[1]), 32'd100);
    end

    // 2. Host write during RUN is deferred to the first IDLE clock.
    idle(5);
    nh = hw_q.size();
    host_write(12'h123, 16'hBEEF, 1'b1);
    wait_len("timeout_ov_run2", 1, ov_q.size() + 1, 100);
    idle(2);
    chk("run_wr_once", 32'(hw_q.size()), 32'(nh + 1));
    if (hw_q.size() > 0 && ov_q.size() > 0)
      chk("run_wr_first_idle", 32'(hw_q[$]), 32'(ov_q[$] + 1));

    // 3. Three queued writes drain before a pending tick starts the sequencer.
    n_run = 110;
    wait_len("timeout_rd_long", 0, rd_q.size() + 1, 200);
    idle(5);
    host_write(12'h201, 16'h1111, 1'b1);
    host_write(12'h202, 16'h2222, 1'b1);
    host_write(12'h203, 16'h3333, 1'b1);
    n_run = 40;
    nr = rd_q.size();
    wait_len("timeout_rd_after_drain", 0, nr + 1, 300);
    idle(1);
    if (hw_q.size() >= 3 && rd_q.size() > nr && ov_q.size() > 0) begin
      chk("drain_wr3", 32'(hw_q[$]),              32'(rd_q[nr] - 1));
      chk("drain_wr2", 32'(hw_q[hw_q.size()-2]),  32'(rd_q[nr] - 2));
      chk("drain_wr1", 32'(hw_q[hw_q.size()-3]),  32'(rd_q[nr] - 3));
      chk("drain_after_capture", 32'(hw_q[hw_q.size()-3]), 32'(ov_q[$] + 1));
    end

    // 4. Runs longer than the tick period raise a sticky overrun.
    n_run = 150;
    for (int i = 0; i < 1500 && bus.overrun !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    n_run = 40;
    wait_len("timeout_ov_settle", 1, ov_q.size() + 3, 1200);
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    idle(1);
    bus.overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(bus.overrun), 32'd0);

    // 5. Queue fills at DEPTH during RUN; the extra write is dropped.
    wait_len("timeout_rd_fill", 0, rd_q.size() + 1, 200);
    idle(3);
    nh = hw_q.size();
    host_write(12'h301, 16'hA001, 1'b1);
    host_write(12'h302, 16'hA002, 1'b1);
    host_write(12'h303, 16'hA003, 1'b1);
    chk("not_full_after_3", 32'(bus.host_full), 32'd0);
    host_write(12'h304, 16'hA004, 1'b1);
    chk("full_after_4", 32'(bus.host_full), 32'd1);
    host_write(12'h305, 16'hA005, 1'b0);
    chk("host_drop_set", 32'(bus.host_drop), 32'd1);
    wait_len("timeout_ov_fill", 1, ov_q.size() + 1, 100);
    idle(8);
    chk("drained_four", 32'(hw_q.size() - nh), 32'd4);
    chk("full_cleared", 32'(bus.host_full), 32'd0);
    bus.overrun_clr = 1'b1;
    idle(1);
    bus.overrun_clr = 1'b0;
    chk("host_drop_cleared", 32'(bus.host_drop), 32'd0);

    // 6. Reset in the middle of a run.
    wait_len("timeout_rd_pre_reset", 0, rd_q.size() + 1, 200);
    idle(5);
    reset = 1'b1;
    idle(1);
    kr    = cyc;
    reset = 1'b0;
    check_zero_outputs("midrun_reset");
    chk("midrun_reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    nr = rd_q.size();
    wait_len("timeout_rd_post_reset", 0, nr + 1, 300);
    if (rd_q.size() > nr) chk("post_reset_rd_cycle", 32'(rd_q[nr]), 32'(kr + 100));
    wait_len("timeout_ov_post_reset", 1, ov_q.size() + 1, 100);

    chk("wr_scoreboard_empty",   32'(exp_wr_q.size()), 32'd0);
    chk("samp_scoreboard_empty", 32'(samp_c_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
